// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scanning N:1 channel multiplexer.
// Imported by the top level and the next-channel search block.
package scan_mux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_next_ch.sv
// Finds the first enabled channel strictly after ptr_i, wrapping at
// CHANNELS-1; any_o flags that at least one channel is enabled.
module scan_next_ch
   import scan_mux_pkg::*;
#(
   parameter  int CHANNELS = 8,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [SEL_W-1:0]    ptr_i,
   input  logic [CHANNELS-1:0] mask_i,
   output logic [SEL_W-1:0]    nxt_o,
   output logic                any_o
);

   localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

   logic [SEL_W:0]   sum;
   logic [SEL_W-1:0] idx;

   // Walk the farthest candidate first so the closest enabled one wins.
   always_comb begin
      nxt_o = ptr_i;
      sum   = '0;
      idx   = '0;
      for (int i = CHANNELS; i >= 1; i--) begin
         sum = {1'b0, ptr_i} + (SEL_W+1)'(i);
         if (sum >= NCH) begin
            sum = sum - NCH;
         end
         idx = sum[SEL_W-1:0];
         if (mask_i[idx]) begin
            nxt_o = idx;
         end
      end
   end

   assign any_o = |mask_i;

endmodule

// File: rtl/scan_mux_nx1.sv
// N:1 channel multiplexer with manual select and auto-scan over an
// enable mask; one indexed read feeds a single registered output.
module scan_mux_nx1
   import scan_mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 8,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       en_mask,
   input  logic                      hold,
   output logic [WIDTH-1:0]          dout,
   output logic [SEL_W-1:0]          dout_ch,
   output logic                      dout_valid
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] din_a [CHANNELS];
   logic             sel_ok;
   logic [SEL_W-1:0] sel_idx;
   logic             sel_en;
   logic             entering;
   logic [SEL_W-1:0] base;
   logic [SEL_W-1:0] nxt_ch;
   logic             any_en;
   logic             is_man, is_hold, is_adv;
   logic [SEL_W-1:0] cap_idx;
   logic             load;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
      assign din_a[k] = din[k*WIDTH +: WIDTH];
   end

   if (CHANNELS == (1 << SEL_W)) begin : g_pow2
      assign sel_ok = 1'b1;
   end else begin : g_npow2
      assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
   end

   assign sel_idx = sel_ok ? sel : '0;
   assign sel_en  = sel_ok && en_mask[sel_idx];

   // Searching after LAST makes entry start from the lowest enabled index.
   assign entering = (state_q != SCAN);
   assign base     = entering ? LAST : ptr_q;

   scan_next_ch #(
      .CHANNELS (CHANNELS)
   ) u_next (
      .ptr_i  (base),
      .mask_i (en_mask),
      .nxt_o  (nxt_ch),
      .any_o  (any_en)
   );

   assign is_man  = (mode == MODE_MANUAL);
   assign is_hold = !is_man && hold && !entering;
   assign is_adv  = !is_man && !is_hold;

   always_comb begin
      state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
      ptr_d   = ptr_q;
      cap_idx = ptr_q;
      load    = 1'b0;
      unique case (1'b1)
         is_man: begin
            cap_idx = sel_idx;
            load    = sel_en;
         end
         is_hold: begin
            cap_idx = ptr_q;
            load    = en_mask[ptr_q];
         end
         is_adv: begin
            cap_idx = nxt_ch;
            load    = any_en;
            if (any_en) begin
               ptr_d = nxt_ch;
            end
         end
         default: ;
      endcase
      dout_d  = load ? din_a[cap_idx] : dout_q;
      ch_d    = load ? cap_idx : ch_q;
      valid_d = load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         dout_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         dout_q  <= dout_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
      end
   end

   assign dout       = dout_q;
   assign dout_ch    = ch_q;
   assign dout_valid = valid_q;

endmodule

// File: tb/tb_scan_mux_nx1.sv
// Bench for scan_mux_nx1: directed scenarios plus random traffic
// compared against an enabled-list reference model.
module tb_scan_mux_nx1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  dval [8];
   logic [63:0] din;
   logic [2:0]  sel;
   logic        mode;
   logic [7:0]  en_mask;
   logic        hold;
   logic [7:0]  dout;
   logic [2:0]  dout_ch;
   logic        dout_valid;

   logic [7:0]  d6 [6];
   logic [47:0] din6;
   logic [2:0]  sel6;
   logic [5:0]  mask6;
   logic [7:0]  dout6;
   logic [2:0]  dout_ch6;
   logic        dout_valid6;

   int          ntests = 0;
   int          nfail  = 0;

   int          m_state;
   int          m_ptr;
   int          m_ch;
   logic [7:0]  m_dout;
   logic        m_valid;

   always #5 clk = ~clk;

   always_comb begin
      din = '0;
      for (int k = 0; k < 8; k++) din[k*8 +: 8] = dval[k];
   end

   always_comb begin
      din6 = '0;
      for (int k = 0; k < 6; k++) din6[k*8 +: 8] = d6[k];
   end

   scan_mux_nx1 #(.WIDTH(8), .CHANNELS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .sel        (sel),
      .mode       (mode),
      .en_mask    (en_mask),
      .hold       (hold),
      .dout       (dout),
      .dout_ch    (dout_ch),
      .dout_valid (dout_valid)
   );

   scan_mux_nx1 #(.WIDTH(8), .CHANNELS(6)) dut6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din6),
      .sel        (sel6),
      .mode       (1'b0),
      .en_mask    (mask6),
      .hold       (1'b0),
      .dout       (dout6),
      .dout_ch    (dout_ch6),
      .dout_valid (dout_valid6)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_ptr   = 0;
      m_ch    = 0;
      m_dout  = 8'h00;
      m_valid = 1'b0;
   endtask

   task automatic capture(input int k);
      m_dout  = dval[k];
      m_ch    = k;
      m_valid = 1'b1;
   endtask

   // Reference: list the enabled channels, pick the first one above
   // the start point, otherwise wrap to the first one in the list.
   task automatic model_step();
      int  q[$];
      int  start;
      int  pick;
      bit  entering;
      entering = (m_state != 2);
      if (mode == 1'b0) begin
         m_state = 1;
         if (en_mask[sel]) capture(int'(sel));
         else m_valid = 1'b0;
      end else begin
         m_state = 2;
         if (hold && !entering) begin
            if (en_mask[m_ptr]) capture(m_ptr);
            else m_valid = 1'b0;
         end else begin
            for (int k = 0; k < 8; k++) if (en_mask[k]) q.push_back(k);
            if (q.size() == 0) begin
               m_valid = 1'b0;
            end else begin
               start = entering ? -1 : m_ptr;
               pick  = -1;
               foreach (q[j]) if (pick < 0 && q[j] > start) pick = q[j];
               if (pick < 0) pick = q[0];
               m_ptr = pick;
               capture(pick);
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_dout"}, 32'(dout), 32'(m_dout));
      check({tag, "_ch"}, 32'(dout_ch), 32'(m_ch));
      check({tag, "_valid"}, 32'(dout_valid), 32'(m_valid));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic rand_din();
      for (int k = 0; k < 8; k++) dval[k] = 8'($urandom);
   endtask

   function automatic logic [7:0] rand_mask();
      logic [7:0] m;
      case ($urandom_range(0, 3))
         0:       m = 8'h00;
         1:       m = 8'h01 << $urandom_range(0, 7);
         default: m = 8'($urandom);
      endcase
      return m;
   endfunction

   initial begin
      int         exp_seq [6];
      logic [7:0] v;
      exp_seq = '{0, 2, 5, 7, 0, 2};

      rst_n   = 1'b0;
      mode    = 1'b0;
      sel     = 3'd5;
      en_mask = 8'hFF;
      hold    = 1'b0;
      for (int k = 0; k < 8; k++) dval[k] = 8'h10 + 8'(k);
      for (int k = 0; k < 6; k++) d6[k] = 8'hA0 + 8'(k);
      sel6  = 3'd3;
      mask6 = 6'h3F;
      model_reset();

      #2;
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_ch", 32'(dout_ch), 32'h0);
      check("rst_valid", 32'(dout_valid), 32'h0);
      check("rst_valid6", 32'(dout_valid6), 32'h0);

      #10 rst_n = 1'b1;
      step();
      check_model("man5");
      check("man5_dout", 32'(dout), 32'h15);
      check("man5_ch", 32'(dout_ch), 32'd5);
      check("man5_valid", 32'(dout_valid), 32'd1);
      check("c6_dout", 32'(dout6), 32'hA3);
      check("c6_valid", 32'(dout_valid6), 32'd1);

      sel6 = 3'd7;
      d6[3] = 8'h5C;
      step();
      check_model("man5b");
      check("c6_sel7_valid", 32'(dout_valid6), 32'd0);
      check("c6_sel7_dout", 32'(dout6), 32'hA3);
      check("c6_sel7_ch", 32'(dout_ch6), 32'd3);

      sel6  = 3'd2;
      mask6 = 6'b111011;
      step();
      check("c6_dis_valid", 32'(dout_valid6), 32'd0);
      check("c6_dis_dout", 32'(dout6), 32'hA3);

      for (int i = 0; i < 20; i++) begin
         rand_din();
         sel     = 3'($urandom);
         en_mask = rand_mask();
         hold    = 1'($urandom);
         step();
         check_model("man_rnd");
      end

      hold    = 1'b0;
      mode    = 1'b1;
      en_mask = 8'b1010_0101;
      for (int i = 0; i < 6; i++) begin
         rand_din();
         step();
         check_model("skip");
         check("skip_ch", 32'(dout_ch), 32'(exp_seq[i]));
         check("skip_valid", 32'(dout_valid), 32'd1);
      end

      en_mask = 8'h00;
      for (int i = 0; i < 3; i++) begin
         rand_din();
         step();
         check_model("empty");
         check("empty_ch", 32'(dout_ch), 32'd2);
         check("empty_valid", 32'(dout_valid), 32'd0);
      end
      en_mask = 8'hFF;
      step();
      check_model("resume");
      check("resume_ch", 32'(dout_ch), 32'd3);

      step();
      check("pre_hold_ch", 32'(dout_ch), 32'd4);
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v = 8'($urandom);
         dval[4] = v;
         step();
         check_model("hold");
         check("hold_ch", 32'(dout_ch), 32'd4);
         check("hold_dout", 32'(dout), 32'(v));
      end
      hold = 1'b0;
      step();
      check("unhold_ch", 32'(dout_ch), 32'd5);

      for (int i = 0; i < 60; i++) begin
         rand_din();
         en_mask = rand_mask();
         hold    = ($urandom_range(0, 3) == 0);
         mode    = ($urandom_range(0, 9) != 0);
         sel     = 3'($urandom);
         step();
         check_model("scan_rnd");
      end

      mode    = 1'b1;
      hold    = 1'b0;
      en_mask = 8'hFF;
      step();
      step();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_dout", 32'(dout), 32'h0);
      check("arst_ch", 32'(dout_ch), 32'h0);
      check("arst_valid", 32'(dout_valid), 32'h0);
      en_mask = 8'b0000_1000;
      #2 rst_n = 1'b1;
      step();
      check_model("post_rst");
      check("post_rst_ch", 32'(dout_ch), 32'd3);
      check("post_rst_valid", 32'(dout_valid), 32'd1);
      rand_din();
      step();
      check_model("single");
      check("single_ch", 32'(dout_ch), 32'd3);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/scan_mux_nx1.md
SCAN_MUX_NX1 -- requirements
Module: scan_mux_nx1

Interface
REQ-001 Parameter WIDTH, default 8: data width of each input channel.
REQ-002 Parameter CHANNELS, default 8: number of input channels; legal range 2..64.
REQ-003 Derived constant SEL_W = clog2(CHANNELS): channel-index width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 din  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel index used in manual mode.
REQ-008 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 en_mask  input  CHANNELS  per-channel enable; bit k = 1 makes channel k eligible.
REQ-010 hold  input  1  freezes the scan pointer in auto-scan mode.
REQ-011 dout  output  WIDTH  registered selected data.
REQ-012 dout_ch  output  SEL_W  index of the channel captured in dout.
REQ-013 dout_valid  output  1  dout/dout_ch carry a legal, enabled channel sample.

Function
REQ-014 The FSM SHALL have states IDLE, MANUAL and SCAN; IDLE is entered only from reset.
REQ-015 IDLE SHALL go to MANUAL when mode = 0, or to SCAN when mode = 1, on the first clock after reset release.
REQ-016 MANUAL SHALL go to SCAN when mode = 1, and SCAN SHALL go to MANUAL when mode = 0, each on the sampling edge.
REQ-017 In MANUAL, each edge SHALL load dout = din[sel], dout_ch = sel and dout_valid = 1, provided sel < CHANNELS and en_mask[sel] = 1.
REQ-018 In MANUAL with sel >= CHANNELS or en_mask[sel] = 0, dout and dout_ch SHALL hold and dout_valid SHALL be 0.
REQ-019 Latency from din/sel to dout SHALL be exactly 1 clock in both modes.
REQ-020 In SCAN, an internal pointer ptr (SEL_W bits) SHALL advance each edge to the next enabled channel strictly after ptr, in ascending order.
REQ-021 Pointer advance SHALL wrap from CHANNELS-1 to 0 and SHALL skip disabled channels within the same cycle.
REQ-022 In SCAN, each edge SHALL load dout = din[next ptr], dout_ch = next ptr and dout_valid = 1.
REQ-023 On entry to SCAN from IDLE or MANUAL, the first captured channel SHALL be the lowest enabled index >= 0.
REQ-024 If only one channel is enabled, SCAN SHALL capture that channel every cycle.
REQ-025 If en_mask = 0 in SCAN, ptr, dout and dout_ch SHALL hold and dout_valid SHALL be 0.
REQ-026 Scanning SHALL resume from the lowest enabled index after ptr when the mask becomes nonzero again.
REQ-027 hold = 1 in SCAN SHALL freeze ptr while continuing to recapture din[ptr] each cycle, with dout_valid = 1 if en_mask[ptr] = 1 and 0 otherwise.
REQ-028 hold SHALL be ignored in MANUAL.
REQ-029 A mask change SHALL take effect on the same edge on which it is sampled, so a disabled channel is never captured with dout_valid = 1.
REQ-030 Simultaneous mode and hold changes SHALL apply the mode transition first; hold is evaluated only in SCAN.

Reset
REQ-031 Asserting rst_n = 0 SHALL immediately force state = IDLE, ptr = 0, dout = 0, dout_ch = 0 and dout_valid = 0, independent of clk.
REQ-032 Reset asserted mid-scan SHALL discard ptr; after release, scanning restarts per REQ-023.
REQ-033 In IDLE, dout_valid SHALL be 0.

Structure
REQ-034 Package scan_mux_pkg SHALL hold the state enum (IDLE, MANUAL, SCAN) and the mode encoding constants (MODE_MANUAL = 0, MODE_SCAN = 1).
REQ-035 Sub-module scan_next_ch SHALL compute the next enabled index after a given pointer, with wrap-around and an any-enabled flag; it SHALL be purely combinational and parametrised by CHANNELS.
REQ-036 The data path SHALL be a single indexed selection feeding one output register bank; no per-channel registers.

Verification
REQ-037 Manual: CHANNELS=8, WIDTH=8, din[k] = 8'h10+k, mask 8'hFF, sel = 5 -> next cycle dout = 8'h15, dout_ch = 5, valid = 1.
REQ-038 Scan with skip: mask 8'b1010_0101, mode = 1 -> dout_ch sequence 0, 2, 5, 7, 0, 2, ... with valid = 1 each cycle.
REQ-039 Empty mask: in SCAN at dout_ch = 2, set mask = 0 for 3 cycles -> valid = 0 and dout_ch holds at 2; restore 8'hFF -> next dout_ch = 3.
REQ-040 Hold: in SCAN at ptr = 4, assert hold for 4 cycles with din[4] changing each cycle -> dout_ch = 4 and dout tracks din[4] with 1-cycle latency; deassert -> dout_ch = 5.
REQ-041 Illegal select: CHANNELS=6, manual sel = 7 -> valid = 0 and dout holds; also en_mask[sel] = 0 -> valid = 0.
REQ-042 Async reset: assert rst_n mid-scan between clock edges -> all outputs 0 immediately; release with mask 8'b0000_1000 -> first valid dout_ch = 3.
